mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage driving a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two half-word accesses (LO then HI). Each
// half is held for HALF_CYCLES cycles. The stage holds ready low for the
// whole access so that upstream stages freeze.
// Optional feature: define MEM_ALIGN_CHECK_EN to short-circuit misaligned
// requests straight to DONE with the misalign flag raised.
module mem_stage #(
  parameter int MEM_BASE    = 1024,
  parameter int HALF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        wb_enable_in,
  input  logic [3:0]  dest_reg_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] val_rm_in,
  input  logic [15:0] sram_rdata,
  output logic        ready,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_result_out,
  output logic        wb_enable_out,
  output logic        mem_read_out,
  output logic [3:0]  dest_reg_out,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_we_n,
  output logic        sram_dq_oe,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] HALF_LAST = 4'(HALF_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  half_cnt;
  logic        half_last;
  logic        request;
  logic        misaligned;
  logic [16:0] word_idx;

  // The writeback fields ride through this stage untouched.
  assign alu_result_out = alu_result_in;
  assign wb_enable_out  = wb_enable_in;
  assign mem_read_out   = mem_read_in;
  assign dest_reg_out   = dest_reg_in;

  assign request   = mem_read_in | mem_write_in;
  assign half_last = (half_cnt == HALF_LAST);

  // Only offset bits [18:2] select the word, and the borrow into them only
  // depends on the low 19 bits. The subtraction is therefore kept at 19 bits.
  assign word_idx = 17'((alu_result_in[18:0] - 19'(MEM_BASE)) >> 2);

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  assign misaligned = ((alu_result_in[1:0] - 2'(MEM_BASE)) != 2'b00);
  assign misalign   = misalign_q;

  // Flag is raised exactly for the DONE cycle reached by the misaligned shortcut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state == IDLE) && request && misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign misalign   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, whatever the block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Half-access cycle counter. It wraps to zero on the last cycle of each
  // half, so it is already cleared on entry to LO and to HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          half_cnt <= '0;
    else if ((state == LO || state == HI) && !half_last) half_cnt <= half_cnt + 4'd1;
    else                                              half_cnt <= '0;
  end

  // Next-state logic and the SRAM/handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case, so that no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt  = state;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        ready = !request;
        if (request) state_nxt = misaligned ? DONE : LO;
      end
      LO: begin
        sram_addr = {word_idx, 1'b0};
        if (mem_write_in) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
          sram_wdata = val_rm_in[15:0];
        end
        if (half_last) state_nxt = HI;
      end
      HI: begin
        sram_addr = {word_idx, 1'b1};
        if (mem_write_in) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
          sram_wdata = val_rm_in[31:16];
        end
        if (half_last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load word assembly: each half is captured on its last held cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_out <= '0;
    end else if (mem_read_in && half_last) begin
      if (state == LO)      mem_data_out[15:0]  <= sram_rdata;
      else if (state == HI) mem_data_out[31:16] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage using the default parameters
// (MEM_BASE=1024, HALF_CYCLES=2). A behavioural 16-bit SRAM sits on the bus.
// Expected SRAM writes are queued when a store is driven and popped by a bus
// monitor. Expected load words and ready-low lengths are queued per access
// and popped in the DONE cycle. The MEM_ALIGN_CHECK_EN build is also handled.
module tb_mem_stage;

  localparam int HALF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in, wb_enable_in;
  logic [3:0]  dest_reg_in;
  logic [31:0] alu_result_in, val_rm_in;
  logic [15:0] sram_rdata;
  logic        ready;
  logic [31:0] mem_data_out, alu_result_out;
  logic        wb_enable_out, mem_read_out;
  logic [3:0]  dest_reg_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we_n, sram_dq_oe, misalign;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          low;
    logic        mis;
  } acc_t;

  wr_t  wr_exp_q[$];
  acc_t acc_exp_q[$];

  logic [15:0] sram_mem [0:63];
  logic [31:0] last_load;
  int n_checks = 0;
  int n_pass   = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_enable_in(wb_enable_in), .dest_reg_in(dest_reg_in),
    .alu_result_in(alu_result_in), .val_rm_in(val_rm_in),
    .sram_rdata(sram_rdata), .ready(ready), .mem_data_out(mem_data_out),
    .alu_result_out(alu_result_out), .wb_enable_out(wb_enable_out),
    .mem_read_out(mem_read_out), .dest_reg_out(dest_reg_out),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
    .sram_dq_oe(sram_dq_oe), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write on the clock edge while we_n is low.
  assign sram_rdata = sram_mem[sram_addr[5:0]];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Bus monitor: every write cycle seen must match the head of the write scoreboard.
  always @(negedge clk) begin
    if (!rst && !sram_we_n) begin
      check("wr_expected", 32'(wr_exp_q.size() > 0), 32'd1);
      if (wr_exp_q.size() > 0) begin
        wr_t w;
        w = wr_exp_q.pop_front();
        check("wr_addr", 32'(sram_addr), 32'(w.addr));
        check("wr_data", 32'(sram_wdata), 32'(w.data));
        check("wr_oe", 32'(sram_dq_oe), 32'd1);
      end
    end
  end

  task automatic push_store(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] offs;
    wr_t w;
    offs = addr - 32'd1024;
    for (int i = 0; i < HALF; i++) begin
      w.addr = {offs[18:2], 1'b0}; w.data = data[15:0];  wr_exp_q.push_back(w);
    end
    for (int i = 0; i < HALF; i++) begin
      w.addr = {offs[18:2], 1'b1}; w.data = data[31:16]; wr_exp_q.push_back(w);
    end
  endtask

  // Drive one access (called just after a rising edge). Wait, within a
  // bounded number of cycles, for the DONE cycle and score it.
  task automatic access(input string tag, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input int exp_low, input logic exp_mis);
    acc_t a;
    int   low;
    bit   seen;
    a.tag = tag; a.data = exp_data; a.low = exp_low; a.mis = exp_mis;
    acc_exp_q.push_back(a);
    if (!rd && exp_low > 1) push_store(addr, wdata);
    mem_read_in   = rd;
    mem_write_in  = !rd;
    wb_enable_in  = rd;
    dest_reg_in   = 4'd3;
    alu_result_in = addr;
    val_rm_in     = wdata;
    low  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin seen = 1'b1; break; end
      low++;
    end
    a = acc_exp_q.pop_front();
    check({a.tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({a.tag, "_ready_low"}, 32'(low), 32'(a.low));
      check({a.tag, "_data"}, mem_data_out, a.data);
      check({a.tag, "_misalign"}, 32'(misalign), 32'(a.mis));
    end
    @(posedge clk); #1;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0000;
    sram_mem[0]  = 16'hAAAA; sram_mem[1]  = 16'h5555;
    sram_mem[8]  = 16'h5678; sram_mem[9]  = 16'h1234;
    sram_mem[62] = 16'h0F0F; sram_mem[63] = 16'hF0F0;
    rst = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; wb_enable_in = 1'b0;
    dest_reg_in = 4'd0; alu_result_in = 32'd0; val_rm_in = 32'd0;
    last_load = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_data", mem_data_out, 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    mem_read_in = 1'b1; #1;
    check("rst_ready_req", 32'(ready), 32'd0);
    mem_read_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory op: ready stays high, bus quiet, fields pass through.
    wb_enable_in = 1'b1; dest_reg_in = 4'd5; alu_result_in = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nop_ready", 32'(ready), 32'd1);
      check("nop_we_n", 32'(sram_we_n), 32'd1);
      check("nop_addr", 32'(sram_addr), 32'd0);
      check("nop_wb", 32'(wb_enable_out), 32'd1);
      check("nop_dest", 32'(dest_reg_out), 32'd5);
      check("nop_alu", alu_result_out, 32'h0000_1234);
      check("nop_mrd", 32'(mem_read_out), 32'd0);
    end
    @(posedge clk); #1;

    // Store then read back; a store leaves mem_data_out alone.
    access("st1028", 1'b0, 32'd1028, 32'hDEADBEEF, last_load, 2 * HALF + 1, 1'b0);
    // DONE lasts a single cycle: a request seen right after it is back in IDLE.
    mem_write_in = 1'b1;
    @(negedge clk);
    check("done_once_ready", 32'(ready), 32'd0);
    check("done_once_we_n", 32'(sram_we_n), 32'd1);
    mem_write_in = 1'b0;
    @(posedge clk); #1;

    last_load = 32'hDEADBEEF;
    access("ld1028", 1'b1, 32'd1028, 32'd0, last_load, 2 * HALF + 1, 1'b0);

    // Address below MEM_BASE wraps to the top of the SRAM.
    last_load = 32'hF0F00F0F;
    access("ld1020", 1'b1, 32'd1020, 32'd0, last_load, 2 * HALF + 1, 1'b0);

    // Back-to-back load then store, then read the store back.
    last_load = 32'h12345678;
    access("b2b_ld", 1'b1, 32'd1040, 32'd0, last_load, 2 * HALF + 1, 1'b0);
    access("b2b_st", 1'b0, 32'd1048, 32'hCAFEF00D, last_load, 2 * HALF + 1, 1'b0);
    last_load = 32'hCAFEF00D;
    access("b2b_rd", 1'b1, 32'd1048, 32'd0, last_load, 2 * HALF + 1, 1'b0);

    // Misaligned load.
`ifdef MEM_ALIGN_CHECK_EN
    access("mis1025", 1'b1, 32'd1025, 32'd0, last_load, 1, 1'b1);
`else
    last_load = 32'h5555AAAA;
    access("mis1025", 1'b1, 32'd1025, 32'd0, last_load, 2 * HALF + 1, 1'b0);
`endif

    // Reset in the second HI cycle of a store.
    push_store(32'd1056, 32'h0BADCAFE);
    mem_write_in = 1'b1; alu_result_in = 32'd1056; val_rm_in = 32'h0BADCAFE;
    repeat (2 * HALF + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_oe", 32'(sram_dq_oe), 32'd0);
    check("midrst_addr", 32'(sram_addr), 32'd0);
    check("midrst_ready_req", 32'(ready), 32'd0);
    check("midrst_data", mem_data_out, 32'd0);
    mem_write_in = 1'b0;
    #1;
    check("midrst_idle", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    last_load = 32'h0BADCAFE;
    access("post_rst_ld", 1'b1, 32'd1056, 32'd0, last_load, 2 * HALF + 1, 1'b0);

    repeat (3) @(posedge clk);
    check("wr_left", 32'(wr_exp_q.size()), 32'd0);
    check("acc_left", 32'(acc_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
